// File: rtl/sass_input_conditioner.sv
// Key/button input conditioner: two-flop sync, shared tick prescaler, per-input
// counting debouncer, lowest-key priority encoder and button press strobes.
module sass_input_conditioner #(
  parameter int TICK_DIV = 1000,
  parameter int DB_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [14:0] keys_raw,
  input  logic [2:0]  btn_raw,
  output logic [14:0] keys_db,
  output logic [3:0]  key_idx,
  output logic        key_valid,
  output logic [2:0]  btn_level,
  output logic [2:0]  btn_pulse,
  output logic        tick
);

  localparam int NIN = 18;
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = $clog2(DB_COUNT + 1);

  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;
  logic [PW-1:0]  r_pre;
  logic           w_tick;
  logic [NIN-1:0] w_db;
  logic [3:0]     w_idx;
  logic           w_any;
  logic [3:0]     r_key_idx;
  logic           r_key_valid;
  logic [2:0]     r_btn_prev;
  logic [2:0]     r_btn_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_raw, keys_raw};
      r_sync2 <= r_sync1;
    end
  end

  // Prescaler freezes (rather than clears) while disabled so timing resumes in phase.
  assign w_tick = en && (r_pre == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (en) begin
      if (w_tick) r_pre <= '0;
      else        r_pre <= r_pre + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_db
      logic          r_d;
      logic [CW-1:0] r_c;
      logic [CW-1:0] w_c_inc;

      assign w_c_inc = r_c + 1'b1;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_d <= 1'b0;
          r_c <= '0;
        end else if (w_tick) begin
          if (r_sync2[gi] != r_d) begin
            if (w_c_inc == CW'(DB_COUNT)) begin
              r_d <= r_sync2[gi];
              r_c <= '0;
            end else begin
              r_c <= w_c_inc;
            end
          end else begin
            // Any agreeing sample throws away a partial count.
            r_c <= '0;
          end
        end
      end

      assign w_db[gi] = r_d;
    end
  endgenerate

  always_comb begin
    w_idx = 4'd0;
    w_any = |w_db[14:0];
    for (int i = 14; i >= 0; i--) begin
      if (w_db[i]) w_idx = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_idx   <= 4'd0;
      r_key_valid <= 1'b0;
      r_btn_prev  <= 3'd0;
      r_btn_pulse <= 3'd0;
    end else begin
      r_key_idx   <= w_idx;
      r_key_valid <= w_any;
      r_btn_prev  <= w_db[17:15];
      r_btn_pulse <= w_db[17:15] & ~r_btn_prev;
    end
  end

  assign keys_db   = w_db[14:0];
  assign btn_level = w_db[17:15];
  assign key_idx   = r_key_idx;
  assign key_valid = r_key_valid;
  assign btn_pulse = r_btn_pulse;
  assign tick      = w_tick;

endmodule

// File: tb/tb_sass_input_conditioner.sv
// Directed bench for sass_input_conditioner with TICK_DIV=4, DB_COUNT=3.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_sass_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [14:0] keys_raw;
  logic [2:0]  btn_raw;
  logic [14:0] keys_db;
  logic [3:0]  key_idx;
  logic        key_valid;
  logic [2:0]  btn_level;
  logic [2:0]  btn_pulse;
  logic        tick;

  int n_vec = 0;
  int n_err = 0;
  int pc    = 0;

  sass_input_conditioner #(.TICK_DIV(4), .DB_COUNT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .keys_raw  (keys_raw),
    .btn_raw   (btn_raw),
    .keys_db   (keys_db),
    .key_idx   (key_idx),
    .key_valid (key_valid),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the prescaler model and check the tick strobe.
  task automatic cyc();
    @(posedge clk);
    if (rst)     pc = 0;
    else if (en) pc = (pc + 1) % 4;
    @(negedge clk);
    chk("tick", {31'd0, tick}, {31'd0, (en && pc == 3)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; keys_raw = '0; btn_raw = '0;
    @(negedge clk);
    run(3);
    chk("rst_keys_db",   {17'd0, keys_db},   32'd0);
    chk("rst_key_idx",   {28'd0, key_idx},   32'd0);
    chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_btn_level", {29'd0, btn_level}, 32'd0);
    chk("rst_btn_pulse", {29'd0, btn_pulse}, 32'd0);

    // Key 5 held from reset release: rises on cycle 12.
    keys_raw = 15'h0020; rst = 1'b0;
    run(11);
    chk("k5_before", {17'd0, keys_db}, 32'h0);
    run(1);
    chk("k5_rise",   {17'd0, keys_db}, 32'h20);
    chk("k5_valid_lag", {31'd0, key_valid}, 32'd0);
    run(1);
    chk("k5_idx",    {28'd0, key_idx},   32'd5);
    chk("k5_valid",  {31'd0, key_valid}, 32'd1);

    // Button 2 bounce 1,0,1 then held.
    run(3);
    btn_raw = 3'b100; run(4); chk("b_bounce1", {29'd0, btn_level}, 32'd0);
    btn_raw = 3'b000; run(4); chk("b_bounce0", {29'd0, btn_level}, 32'd0);
    btn_raw = 3'b100; run(4); chk("b_hold1",   {29'd0, btn_level}, 32'd0);
    run(4);                   chk("b_hold2",   {29'd0, btn_level}, 32'd0);
    run(4);                   chk("b_hold3",   {29'd0, btn_level}, 32'd4);
    chk("b_pulse_lag", {29'd0, btn_pulse}, 32'd0);
    run(1); chk("b_pulse",     {29'd0, btn_pulse}, 32'd4);
    run(1); chk("b_pulse_end", {29'd0, btn_pulse}, 32'd0);
    run(2);
    btn_raw = 3'b000;
    for (int i = 0; i < 12; i++) begin
      run(1);
      chk("b_release_pulse", {29'd0, btn_pulse}, 32'd0);
      if (i == 7) chk("b_release_hold", {29'd0, btn_level}, 32'd4);
    end
    chk("b_released", {29'd0, btn_level}, 32'd0);

    // Release key 5, then keys 3 and 9 together, then release 3.
    keys_raw = 15'h0000;
    run(12); chk("k5_release", {17'd0, keys_db}, 32'h0);
    run(1);
    chk("none_valid", {31'd0, key_valid}, 32'd0);
    chk("none_idx",   {28'd0, key_idx},   32'd0);
    run(3);
    keys_raw = 15'h0208;
    run(8); chk("k39_before", {17'd0, keys_db}, 32'h0);
    run(4); chk("k39_rise",   {17'd0, keys_db}, 32'h208);
    run(1); chk("k39_idx",    {28'd0, key_idx}, 32'd3);
    chk("k39_valid", {31'd0, key_valid}, 32'd1);
    run(3);
    keys_raw = 15'h0200;
    run(12); chk("k3_release", {17'd0, keys_db}, 32'h200);
    run(1);  chk("k9_idx",     {28'd0, key_idx}, 32'd9);
    run(3);

    // Enable dropped for 20 cycles between the first and second tick of key 0.
    keys_raw = 15'h0201;
    run(4); run(2);
    en = 1'b0;
    run(20);
    chk("en0_hold", {17'd0, keys_db}, 32'h200);
    en = 1'b1;
    run(2); chk("en1_second", {17'd0, keys_db}, 32'h200);
    run(4); chk("en1_third",  {17'd0, keys_db}, 32'h201);
    run(1); chk("k0_idx",     {28'd0, key_idx}, 32'd0);
    chk("k0_valid", {31'd0, key_valid}, 32'd1);
    run(3);

    // Reset mid-debounce of key 14 discards everything.
    keys_raw = 15'h4201;
    run(8);
    rst = 1'b1;
    run(1);
    chk("mid_rst_keys_db",   {17'd0, keys_db},   32'd0);
    chk("mid_rst_key_idx",   {28'd0, key_idx},   32'd0);
    chk("mid_rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("mid_rst_btn_level", {29'd0, btn_level}, 32'd0);
    chk("mid_rst_btn_pulse", {29'd0, btn_pulse}, 32'd0);
    rst = 1'b0;
    run(11); chk("post_rst_before", {17'd0, keys_db}, 32'h0);
    run(1);  chk("post_rst_rise",   {17'd0, keys_db}, 32'h4201);
    run(1);
    chk("post_rst_idx",   {28'd0, key_idx},   32'd0);
    chk("post_rst_valid", {31'd0, key_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sass_input_conditioner.md
SASS_INPUT_CONDITIONER -- requirements
Module: sass_input_conditioner

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clk cycles per debounce sample tick (legal range >= 2).
REQ-002 SHALL have parameter DB_COUNT, default 4: consecutive disagreeing sample ticks required to accept a new level (legal range >= 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: conditioner enable, active-high.
REQ-006 SHALL have port keys_raw, input, 15 bits: asynchronous piano key pins, 1 = pressed.
REQ-007 SHALL have port btn_raw, input, 3 bits: asynchronous buttons; [0] seq_power, [1] tempo_select, [2] seq_play.
REQ-008 SHALL have port keys_db, output, 15 bits: debounced key levels, to sass_synth piano_keys.
REQ-009 SHALL have port key_idx, output, 4 bits: index of the lowest pressed debounced key.
REQ-010 SHALL have port key_valid, output, 1 bit: high when any debounced key is pressed.
REQ-011 SHALL have port btn_level, output, 3 bits: debounced button levels.
REQ-012 SHALL have port btn_pulse, output, 3 bits: one-cycle press strobes.
REQ-013 SHALL have port tick, output, 1 bit: sample tick strobe, for observation.

Function
REQ-014 All 18 raw inputs SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 A prescaler SHALL count 0..TICK_DIV-1 while en=1, assert tick for exactly the cycle its count equals TICK_DIV-1, then wrap to 0.
REQ-016 While en=0, the prescaler SHALL hold its count and tick SHALL be 0.
REQ-017 Each input SHALL have a debounced level D and a disagreement counter C of width clog2(DB_COUNT+1).
REQ-018 On a tick with sync != D: C SHALL increment; when the incremented value equals DB_COUNT, D SHALL take the sync value and C SHALL clear, both in that same cycle.
REQ-019 On a tick with sync == D, C SHALL clear to 0; a single agreeing tick restarts the count (glitch rejection).
REQ-020 Between ticks, D and C SHALL hold.
REQ-021 keys_db and btn_level SHALL be the D registers directly, with no extra latency.
REQ-022 key_idx and key_valid SHALL be registered and SHALL reflect keys_db one cycle later; lowest set index wins; key_idx=0 when key_valid=0.
REQ-023 btn_pulse[i] SHALL be high for exactly one cycle, the cycle after btn_level[i] goes 0->1; release SHALL produce no pulse.
REQ-024 Simultaneous keys SHALL debounce independently; several D registers may update on the same tick.
REQ-025 Worst-case press latency SHALL be 2 sync cycles + DB_COUNT*TICK_DIV cycles.

Reset
REQ-026 When rst=1 at a clock edge, prescaler, all C, all D, synchronizer flops, key_idx, key_valid, btn_pulse and tick SHALL clear to 0 on that edge.
REQ-027 rst SHALL take priority over en and over any in-progress count; an assertion mid-debounce SHALL discard the partial count.
REQ-028 After rst deasserts with an input held high, that input SHALL require a full DB_COUNT ticks before D rises.

Verification (bench uses TICK_DIV=4, DB_COUNT=3)
REQ-029 Scenario: keys_raw[5]=1 held from reset release -> keys_db[5] rises on the 3rd tick (cycle 12 after release); key_idx=5 and key_valid=1 one cycle later.
REQ-030 Scenario: btn_raw[2] bounce 1,0,1 across successive ticks, then held -> no change until 3 consecutive high ticks; then exactly one btn_pulse[2] cycle; none on release.
REQ-031 Scenario: keys 3 and 9 pressed together and held -> both keys_db bits rise on the same tick; key_idx=3; release key 3 -> key_idx=9 after debounce.
REQ-032 Scenario: en=0 for 20 cycles mid-count -> tick stays 0 and D/C hold; resumes from the held prescaler count when en=1.
REQ-033 Scenario: rst pulsed after 2 disagreeing ticks -> all outputs 0 next cycle; the key needs 3 fresh ticks after release.
REQ-034 Scenario: prescaler wrap -> tick exactly one cycle in every 4, with no gap or double strobe at the 3->0 boundary.
